// File: rtl/serving_brg_master.sv
// ---------------------------------------------------------------------------
// serving_brg_master
//
// Byte-stream command engine that masters the bridge port of the serving SoC.
// A host link delivers framed commands:
//   byte 0 : opcode  {write, 3'b000, sel[3:0]}
//   byte 1 : {6'bx, adr[11:10]}
//   byte 2 : adr[9:2]
//   bytes 3..6 (writes only) : write data, MSB first
// The frame is turned into one bridge access (SETUP cycle, then a strobe held
// until ack or timeout). The engine answers with ACK_BYTE for a write, four
// read-data bytes (MSB first) for a read, 8'hEE on timeout, or 8'hE0 for an
// illegal opcode.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/i_cmd_data       command byte stream in
//   o_cmd_ready                  command byte accepted when high with valid
//   o_rsp_valid/o_rsp_data       response byte stream out
//   i_rsp_ready                  host consumes the response byte
//   adr_brg, data_brg            bridge word address [11:2] and write data
//   stb_brg, wen_brg, sel_brg    bridge strobe, write enable, byte lane mask
//   rdt_brg, ack_brg             bridge read data and acknowledge
//   sel_wadr, sel_wdata, sel_wen,
//   sel_radr, sel_rdata          bridge ownership selects
// ---------------------------------------------------------------------------
module serving_brg_master #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [7:0]  ACK_BYTE = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  input  logic        i_rsp_ready,
  output logic [9:0]  adr_brg,
  output logic [31:0] data_brg,
  output logic        stb_brg,
  output logic        wen_brg,
  output logic [3:0]  sel_brg,
  input  logic [31:0] rdt_brg,
  input  logic        ack_brg,
  output logic        sel_wadr,
  output logic        sel_wdata,
  output logic        sel_wen,
  output logic        sel_radr,
  output logic        sel_rdata
);

  localparam int unsigned   TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    ERR_OPCODE  = 8'hE0;
  localparam logic [7:0]    ERR_TIMEOUT = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR_HI,
    S_ADR_LO,
    S_DATA,
    S_SETUP,
    S_ISSUE,
    S_RSP,
    S_ERR
  } state_e;

  state_e        state_q;

  // Frame shadow registers: the bridge outputs only change once a whole
  // frame has arrived, so a partially received frame never disturbs them.
  logic          op_wr_q;
  logic [3:0]    op_sel_q;
  logic [1:0]    adr_hi_q;
  logic [7:0]    adr_lo_q;
  logic [23:0]   wdata_q;
  logic [1:0]    byte_cnt_q;

  logic [TW-1:0] tmo_q;
  logic [23:0]   rsp_sr_q;
  logic [1:0]    rsp_left_q;

  // Registered outputs
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic [9:0]    adr_q;
  logic [31:0]   data_q;
  logic          stb_q;
  logic          wen_q;
  logic [3:0]    sel_q;
  logic          sel_wadr_q;
  logic          sel_wdata_q;
  logic          sel_wen_q;
  logic          sel_radr_q;
  logic          sel_rdata_q;

  logic          cmd_fire;
  logic          rsp_fire;
  logic          frame_done;
  logic [7:0]    frame_adr_lo;
  logic          bus_ack;
  logic          bus_tmo;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cmd_fire     = i_cmd_valid && cmd_ready_q;
    rsp_fire     = rsp_valid_q && i_rsp_ready;
    frame_done   = 1'b0;
    frame_adr_lo = adr_lo_q;
    if (cmd_fire) begin
      if (state_q == S_ADR_LO) begin
        frame_adr_lo = i_cmd_data;
        frame_done   = !op_wr_q;
      end else if (state_q == S_DATA) begin
        frame_done   = (byte_cnt_q == 2'd3);
      end
    end
    // Ack has priority over a timeout landing in the same cycle.
    bus_ack = (state_q == S_ISSUE) && ack_brg;
    bus_tmo = (state_q == S_ISSUE) && !ack_brg && (tmo_q == TMO_LAST);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // behaviour and simulation/synthesis mismatches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      op_sel_q    <= '0;
      adr_hi_q    <= '0;
      adr_lo_q    <= '0;
      wdata_q     <= '0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      rsp_sr_q    <= '0;
      rsp_left_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      adr_q       <= '0;
      data_q      <= '0;
      stb_q       <= 1'b0;
      wen_q       <= 1'b0;
      sel_q       <= '0;
      sel_wadr_q  <= 1'b0;
      sel_wdata_q <= 1'b0;
      sel_wen_q   <= 1'b0;
      sel_radr_q  <= 1'b0;
      sel_rdata_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            op_wr_q  <= i_cmd_data[7];
            op_sel_q <= i_cmd_data[3:0];
            if (i_cmd_data[6:4] != 3'b000) begin
              // Illegal opcode: drop the frame and answer immediately.
              state_q     <= S_ERR;
              cmd_ready_q <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= ERR_OPCODE;
            end else begin
              state_q <= S_ADR_HI;
            end
          end
        end
        S_ADR_HI: begin
          if (cmd_fire) begin
            adr_hi_q <= i_cmd_data[1:0];
            state_q  <= S_ADR_LO;
          end
        end
        S_ADR_LO: begin
          if (cmd_fire) begin
            adr_lo_q   <= i_cmd_data;
            byte_cnt_q <= 2'd0;
            state_q    <= op_wr_q ? S_DATA : S_SETUP;
          end
        end
        S_DATA: begin
          if (cmd_fire) begin
            wdata_q    <= {wdata_q[15:0], i_cmd_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          state_q <= S_ISSUE;
          stb_q   <= 1'b1;
          tmo_q   <= '0;
        end
        S_ISSUE: begin
          if (bus_ack) begin
            state_q     <= S_RSP;
            rsp_valid_q <= 1'b1;
            if (op_wr_q) begin
              rsp_data_q <= ACK_BYTE;
              rsp_left_q <= 2'd0;
            end else begin
              rsp_data_q <= rdt_brg[31:24];
              rsp_sr_q   <= rdt_brg[23:0];
              rsp_left_q <= 2'd3;
            end
          end else if (bus_tmo) begin
            state_q     <= S_RSP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ERR_TIMEOUT;
            rsp_left_q  <= 2'd0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_RSP: begin
          if (rsp_fire) begin
            if (rsp_left_q == 2'd0) begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              rsp_data_q <= rsp_sr_q[23:16];
              rsp_sr_q   <= {rsp_sr_q[15:0], 8'h00};
              rsp_left_q <= rsp_left_q - 2'd1;
            end
          end
        end
        S_ERR: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Complete frame: load the bridge request so it is stable in SETUP.
      if (frame_done) begin
        cmd_ready_q <= 1'b0;
        adr_q       <= {adr_hi_q, frame_adr_lo};
        sel_q       <= op_sel_q;
        wen_q       <= op_wr_q;
        if (op_wr_q) begin
          data_q <= {wdata_q, i_cmd_data};
        end
        sel_wadr_q  <= op_wr_q;
        sel_wdata_q <= op_wr_q;
        sel_wen_q   <= op_wr_q;
        sel_radr_q  <= !op_wr_q;
        // Read data is returned on the core side of the mux.
        sel_rdata_q <= 1'b0;
      end

      // End of the bridge access: release the strobe and the port.
      if (bus_ack || bus_tmo) begin
        stb_q       <= 1'b0;
        sel_wadr_q  <= 1'b0;
        sel_wdata_q <= 1'b0;
        sel_wen_q   <= 1'b0;
        sel_radr_q  <= 1'b0;
        sel_rdata_q <= 1'b0;
      end
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign adr_brg     = adr_q;
  assign data_brg    = data_q;
  assign stb_brg     = stb_q;
  assign wen_brg     = wen_q;
  assign sel_brg     = sel_q;
  assign sel_wadr    = sel_wadr_q;
  assign sel_wdata   = sel_wdata_q;
  assign sel_wen     = sel_wen_q;
  assign sel_radr    = sel_radr_q;
  assign sel_rdata   = sel_rdata_q;

endmodule

// File: tb/tb_serving_brg_master.sv
// ---------------------------------------------------------------------------
// tb_serving_brg_master
//
// Drives framed commands into serving_brg_master, plays the bridge slave and
// the response consumer, and compares every cycle against a frame/queue level
// model of the command engine.
// ---------------------------------------------------------------------------
module tb_serving_brg_master;

  localparam int         TIMEOUT  = 64;
  localparam logic [7:0] ACK_BYTE = 8'hA5;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd_data;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic        i_rsp_ready;
  logic [9:0]  adr_brg;
  logic [31:0] data_brg;
  logic        stb_brg;
  logic        wen_brg;
  logic [3:0]  sel_brg;
  logic [31:0] rdt_brg;
  logic        ack_brg;
  logic        sel_wadr, sel_wdata, sel_wen, sel_radr, sel_rdata;

  always #5 clk = ~clk;

  serving_brg_master #(.TIMEOUT(TIMEOUT), .ACK_BYTE(ACK_BYTE)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_data (i_cmd_data),
    .o_cmd_ready(o_cmd_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .i_rsp_ready(i_rsp_ready),
    .adr_brg    (adr_brg),
    .data_brg   (data_brg),
    .stb_brg    (stb_brg),
    .wen_brg    (wen_brg),
    .sel_brg    (sel_brg),
    .rdt_brg    (rdt_brg),
    .ack_brg    (ack_brg),
    .sel_wadr   (sel_wadr),
    .sel_wdata  (sel_wdata),
    .sel_wen    (sel_wen),
    .sel_radr   (sel_radr),
    .sel_rdata  (sel_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model: frames collected as byte queues, responses as a queue.
  // ------------------------------------------------------------------------
  typedef enum {M_PARSE, M_SETUP, M_ISSUE, M_RSP} mphase_e;

  mphase_e     m_phase = M_PARSE;
  logic [7:0]  m_frame[$];
  logic [7:0]  m_rsp[$];
  logic [7:0]  rx_log[$];
  bit          m_live = 1'b0;
  logic        m_wr   = 1'b0;
  logic [9:0]  m_adr  = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_sel  = '0;
  int          m_stb_len    = 0;
  int          last_stb_len = 0;
  int          n_issue      = 0;
  bit          m_bus;
  logic [4:0]  m_sels;
  int          m_flen;

  always @(negedge clk) begin
    if (m_live) begin
      m_bus  = (m_phase == M_SETUP) || (m_phase == M_ISSUE);
      m_sels = m_bus ? {m_wr, m_wr, m_wr, !m_wr, 1'b0} : 5'b0;
      check("cmd_ready", o_cmd_ready, m_phase == M_PARSE);
      check("rsp_valid", o_rsp_valid, m_phase == M_RSP);
      check("stb_brg", stb_brg, m_phase == M_ISSUE);
      check("selects", {sel_wadr, sel_wdata, sel_wen, sel_radr, sel_rdata}, m_sels);
      check("adr_brg", adr_brg, m_adr);
      check("data_brg", data_brg, m_data);
      check("sel_brg", sel_brg, m_sel);
      if (m_bus) check("wen_brg", wen_brg, m_wr);
      if (m_phase == M_RSP) check("rsp_data", o_rsp_data, m_rsp[0]);
    end

    if (i_rst) begin
      m_live  = 1'b1;
      m_phase = M_PARSE;
      m_frame.delete();
      m_rsp.delete();
      m_wr   = 1'b0;
      m_adr  = '0;
      m_data = '0;
      m_sel  = '0;
    end else if (m_live) begin
      case (m_phase)
        M_PARSE: begin
          if (i_cmd_valid) begin
            m_frame.push_back(i_cmd_data);
            m_flen = m_frame[0][7] ? 7 : 3;
            if (m_frame.size() == 1 && m_frame[0][6:4] != 3'b000) begin
              m_frame.delete();
              m_rsp.delete();
              m_rsp.push_back(8'hE0);
              m_phase = M_RSP;
            end else if (m_frame.size() == m_flen) begin
              m_wr  = m_frame[0][7];
              m_sel = m_frame[0][3:0];
              m_adr = {m_frame[1][1:0], m_frame[2]};
              if (m_wr) m_data = {m_frame[3], m_frame[4], m_frame[5], m_frame[6]};
              m_frame.delete();
              m_phase = M_SETUP;
            end
          end
        end
        M_SETUP: begin
          m_stb_len = 0;
          n_issue++;
          m_phase = M_ISSUE;
        end
        M_ISSUE: begin
          m_stb_len++;
          if (ack_brg) begin
            m_rsp.delete();
            if (m_wr) m_rsp.push_back(ACK_BYTE);
            else begin
              m_rsp.push_back(rdt_brg[31:24]);
              m_rsp.push_back(rdt_brg[23:16]);
              m_rsp.push_back(rdt_brg[15:8]);
              m_rsp.push_back(rdt_brg[7:0]);
            end
            last_stb_len = m_stb_len;
            m_phase = M_RSP;
          end else if (m_stb_len == TIMEOUT) begin
            m_rsp.delete();
            m_rsp.push_back(8'hEE);
            last_stb_len = m_stb_len;
            m_phase = M_RSP;
          end
        end
        M_RSP: begin
          if (i_rsp_ready) begin
            rx_log.push_back(o_rsp_data);
            void'(m_rsp.pop_front());
            if (m_rsp.size() == 0) m_phase = M_PARSE;
          end
        end
        default: m_phase = M_PARSE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Bridge slave: ack after ack_delay strobe cycles (-1 = never), random
  // stray acks while no strobe is active.
  // ------------------------------------------------------------------------
  int          ack_delay     = 0;
  bit          use_fixed_rdt = 1'b0;
  logic [31:0] fixed_rdt     = 32'h0;
  bit          stray_ack     = 1'b1;
  int          stb_cyc       = 0;

  initial begin
    ack_brg = 1'b0;
    rdt_brg = '0;
    forever begin
      @(posedge clk); #1;
      if (stb_brg === 1'b1) begin
        ack_brg = (ack_delay >= 0) && (stb_cyc == ack_delay);
        stb_cyc++;
      end else begin
        stb_cyc = 0;
        ack_brg = stray_ack && ($urandom_range(0, 2) == 0);
      end
      rdt_brg = use_fixed_rdt ? fixed_rdt : $urandom;
    end
  end

  // Response consumer with random backpressure and a forced stall window.
  int stall_cycles = 0;

  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (o_rsp_valid === 1'b1 && stall_cycles > 0) begin
        i_rsp_ready = 1'b0;
        stall_cycles--;
      end else begin
        i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Command driver
  // ------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs;
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin
      i_cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    i_cmd_valid = 1'b1;
    i_cmd_data  = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      hs = (o_cmd_ready === 1'b1);
      @(posedge clk); #1;
      if (hs) begin
        i_cmd_valid = 1'b0;
        return;
      end
    end
    i_cmd_valid = 1'b0;
    bound_expired("cmd_byte_accept");
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) send_byte(bytes[i], gaps);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (m_phase == M_PARSE && m_frame.size() == 0) return;
    end
    bound_expired("return_to_idle");
  endtask

  logic [7:0] fr[$];
  logic [7:0] op;
  int         rx_before;
  int         issue_before;
  bit         wr;

  initial begin
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Reset values
    check("rst_cmd_ready", o_cmd_ready, 1'b1);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_rsp_data", o_rsp_data, 8'h00);
    check("rst_stb", stb_brg, 1'b0);
    check("rst_wen", wen_brg, 1'b0);
    check("rst_data_brg", data_brg, 32'h0);

    // Directed write, ack two cycles after the strobe rises
    ack_delay = 2;
    fr = {8'h88, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(fr, 1'b0);
    wait_idle();
    check("wr_adr", adr_brg, 10'h001);
    check("wr_data", data_brg, 32'hAABBCCDD);
    check("wr_sel", sel_brg, 4'b1000);
    check("wr_stb_len", last_stb_len, 3);
    check("wr_rsp", rx_log[rx_log.size()-1], 8'hA5);

    // Directed read with a 10-cycle response stall
    use_fixed_rdt = 1'b1;
    fixed_rdt     = 32'h12345678;
    ack_delay     = 1;
    stall_cycles  = 10;
    fr = {8'h02, 8'h00, 8'h01};
    send_frame(fr, 1'b0);
    wait_idle();
    check("rd_b0", rx_log[rx_log.size()-4], 8'h12);
    check("rd_b1", rx_log[rx_log.size()-3], 8'h34);
    check("rd_b2", rx_log[rx_log.size()-2], 8'h56);
    check("rd_b3", rx_log[rx_log.size()-1], 8'h78);
    check("rd_data_held", data_brg, 32'hAABBCCDD);

    // Write with no ack: timeout after exactly TIMEOUT strobe cycles
    ack_delay = -1;
    fr = {8'h8F, 8'h00, 8'h04, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(fr, 1'b0);
    wait_idle();
    check("tmo_stb_len", last_stb_len, 64);
    check("tmo_rsp", rx_log[rx_log.size()-1], 8'hEE);
    check("tmo_data", data_brg, 32'hCAFEBABE);
    check("tmo_adr", adr_brg, 10'h004);

    // Ack on the last permitted cycle beats the timeout
    ack_delay = TIMEOUT - 1;
    fr = {8'h81, 8'h03, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr, 1'b0);
    wait_idle();
    check("late_ack_stb_len", last_stb_len, 64);
    check("late_ack_rsp", rx_log[rx_log.size()-1], 8'hA5);
    check("late_ack_adr", adr_brg, 10'h3FF);

    // Illegal opcode, then a normal read
    ack_delay    = 0;
    issue_before = n_issue;
    fr = {8'h10};
    send_frame(fr, 1'b0);
    wait_idle();
    check("err_rsp", rx_log[rx_log.size()-1], 8'hE0);
    check("err_no_stb", n_issue, issue_before);
    fr = {8'h02, 8'h00, 8'h01};
    send_frame(fr, 1'b0);
    wait_idle();
    check("post_err_rd_b0", rx_log[rx_log.size()-4], 8'h12);
    check("post_err_rd_b3", rx_log[rx_log.size()-1], 8'h78);

    // Reset while the strobe is active
    ack_delay = -1;
    fr = {8'h05, 8'h01, 8'h23};
    send_frame(fr, 1'b0);
    for (int i = 0; i < 20 && stb_brg !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    if (stb_brg !== 1'b1) bound_expired("stb_before_reset");
    repeat (3) begin
      @(posedge clk); #1;
    end
    rx_before = rx_log.size();
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("mid_rst_stb", stb_brg, 1'b0);
    check("mid_rst_selects", {sel_wadr, sel_wdata, sel_wen, sel_radr, sel_rdata}, 5'b0);
    check("mid_rst_cmd_ready", o_cmd_ready, 1'b1);
    check("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_rsp", rx_log.size(), rx_before);

    // Randomized frames with gaps, random acks and backpressure
    use_fixed_rdt = 1'b0;
    for (int t = 0; t < 40; t++) begin
      fr.delete();
      wr = 1'($urandom_range(0, 1));
      op = {wr, 3'b000, 4'($urandom)};
      if ($urandom_range(0, 9) == 0) op[6:4] = 3'($urandom_range(1, 7));
      fr.push_back(op);
      if (op[6:4] == 3'b000) begin
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
        if (wr) repeat (4) fr.push_back(8'($urandom));
      end
      ack_delay = $urandom_range(0, 6);
      send_frame(fr, 1'b1);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
